decrypt_frame_loader: RTL

Byte-stream front end of the decryption path, sitting directly upstream of `decrypt_function_1`. It accepts an 11-byte link frame over a valid/ready byte interface, checks the sync bits and the XOR checksum, then strips the framing. It presents the 78-bit packet `data_1`, with the ascending field layout `decrypt_function_1` consumes, behind a one-entry output register with a valid/ready handshake. Bad or stalled frames are dropped and reported as single-cycle error pulses.

---
 rtl/decrypt_pkg.sv | 24 ++
 rtl/decrypt_frame_loader_if.sv | 37 +++
 rtl/frame_out_reg.sv | 58 +++++
 rtl/decrypt_frame_loader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/decrypt_pkg.sv
// Shared definitions for the decryption front end: frame geometry, packet
// field bounds and the loader state encoding.
package decrypt_pkg;

  localparam int FRAME_BYTES = 10;
  localparam int PKT_W       = 78;

  // Ascending bit ranges inside data_1 as consumed by decrypt_function_1.
  localparam int TAG_LO = 0;
  localparam int TAG_HI = 5;
  localparam int KEY_LO = 6;
  localparam int KEY_HI = 16;
  localparam int CT_LO  = 17;
  localparam int CT_HI  = 77;

  localparam logic [1:0] SYNC_DEFAULT = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/decrypt_frame_loader_if.sv
// Byte-in / packet-out bundle of the frame loader.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds its data stable and
// keeps valid high until that edge; ready may change freely between edges.
// Byte channel: in_valid/in_byte from the source, in_ready from the loader.
// Packet channel: out_valid/data_1 from the loader, out_ready from downstream.
interface decrypt_frame_loader_if;
  import decrypt_pkg::*;

  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic [0:PKT_W-1] data_1;
  logic             out_valid;
  logic             out_ready;
  logic             err_sync;
  logic             err_chk;
  logic             err_timeout;
  logic [7:0]       frames_ok;
  state_e           dbg_state;

  // Loader side.
  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, data_1, out_valid, err_sync, err_chk, err_timeout,
           frames_ok, dbg_state
  );

  // Environment side: byte source and packet sink.
  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, data_1, out_valid, err_sync, err_chk, err_timeout,
           frames_ok, dbg_state
  );

endinterface

// File: rtl/frame_out_reg.sv
// One-entry output register for assembled packets: holds data_1/out_valid,
// arbitrates load versus drain and counts loaded packets.
module frame_out_reg
  import decrypt_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [0:PKT_W-1] pkt_i,
  input  logic             out_ready_i,
  output logic             free_o,
  output logic [0:PKT_W-1] data_o,
  output logic             out_valid_o,
  output logic [7:0]       frames_ok_o
);

  logic [0:PKT_W-1] data_q, data_d;
  logic             valid_q, valid_d;
  logic [7:0]       frames_q, frames_d;
  logic             load_ok;

  // The slot can take a packet when it is empty or being drained this edge;
  // a load is ignored otherwise so held data never changes under back-pressure.
  assign free_o  = !valid_q || out_ready_i;
  assign load_ok = load_i && free_o;

  // Next-state: a load wins over a drain on the same edge.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    frames_d = frames_q;
    if (load_ok) begin
      data_d   = pkt_i;
      valid_d  = 1'b1;
      frames_d = frames_q + 8'd1;
    end else if (out_ready_i) begin
      valid_d  = 1'b0;
    end
  end

  // Register the output slot and the packet counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      frames_q <= 8'd0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      frames_q <= frames_d;
    end
  end

  assign data_o      = data_q;
  assign out_valid_o = valid_q;
  assign frames_ok_o = frames_q;

endmodule

// File: rtl/decrypt_frame_loader.sv
// Frame loader: collects an 11-byte link frame, checks sync and XOR checksum,
// strips the framing and hands the 78-bit packet to the output register.
module decrypt_frame_loader
  import decrypt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [1:0]  SYNC        = SYNC_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  decrypt_frame_loader_if.slave bus
);

  localparam int               GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       xor_q, xor_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       buf_q [FRAME_BYTES];
  logic             buf_we;
  logic [3:0]       buf_wr_idx;
  logic             err_sync_q, err_sync_d;
  logic             err_chk_q, err_chk_d;
  logic             err_timeout_q, err_timeout_d;
  logic             in_ready_c;
  logic             accept;
  logic             load;
  logic             out_free;
  logic [0:PKT_W-1] pkt;

  assign in_ready_c = (state_q != PUSH);
  assign accept     = bus.in_valid && in_ready_c;

  // Next-state and control: sync check, byte collection, checksum compare,
  // inter-byte timeout and hand-off to the output register.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    xor_d         = xor_q;
    gap_d         = gap_q;
    buf_we        = 1'b0;
    buf_wr_idx    = idx_q;
    err_sync_d    = 1'b0;
    err_chk_d     = 1'b0;
    err_timeout_d = 1'b0;
    load          = 1'b0;
    case (state_q)
      IDLE: begin
        gap_d = '0;
        if (accept) begin
          if (bus.in_byte[7:6] == SYNC) begin
            buf_we     = 1'b1;
            buf_wr_idx = 4'd0;
            idx_d      = 4'd1;
            xor_d      = bus.in_byte;
            state_d    = COLLECT;
          end else begin
            err_sync_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          gap_d = '0;
          if (idx_q == 4'(FRAME_BYTES)) begin
            // Checksum byte: buffer already holds the whole frame.
            if (bus.in_byte == xor_q) begin
              state_d = PUSH;
            end else begin
              err_chk_d = 1'b1;
              idx_d     = 4'd0;
              xor_d     = 8'd0;
              state_d   = IDLE;
            end
          end else begin
            buf_we = 1'b1;
            xor_d  = xor_q ^ bus.in_byte;
            idx_d  = idx_q + 4'd1;
          end
        end else if (gap_q == GAP_LAST) begin
          // This idle edge would bring the gap to TIMEOUT_CYC.
          err_timeout_d = 1'b1;
          idx_d         = 4'd0;
          xor_d         = 8'd0;
          gap_d         = '0;
          state_d       = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      PUSH: begin
        gap_d = '0;
        if (out_free) begin
          load    = 1'b1;
          idx_d   = 4'd0;
          xor_d   = 8'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and error-pulse registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      idx_q         <= 4'd0;
      xor_q         <= 8'd0;
      gap_q         <= '0;
      err_sync_q    <= 1'b0;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      xor_q         <= xor_d;
      gap_q         <= gap_d;
      err_sync_q    <= err_sync_d;
      err_chk_q     <= err_chk_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Assembly buffer, kept apart from data_1 so the next frame can be
  // collected while the previous packet waits downstream.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < FRAME_BYTES; i++) buf_q[i] <= 8'd0;
    end else if (buf_we) begin
      buf_q[buf_wr_idx] <= bus.in_byte;
    end
  end

  // Strip the two sync bits: packet bit i is frame bit i+2.
  always_comb begin
    pkt                = '0;
    pkt[TAG_LO:TAG_HI] = buf_q[0][5:0];
    pkt[KEY_LO:KEY_HI] = {buf_q[1], buf_q[2][7:5]};
    pkt[CT_LO:CT_HI]   = {buf_q[2][4:0], buf_q[3], buf_q[4], buf_q[5],
                          buf_q[6], buf_q[7], buf_q[8], buf_q[9]};
  end

  frame_out_reg u_out (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .load_i      (load),
    .pkt_i       (pkt),
    .out_ready_i (bus.out_ready),
    .free_o      (out_free),
    .data_o      (bus.data_1),
    .out_valid_o (bus.out_valid),
    .frames_ok_o (bus.frames_ok)
  );

  assign bus.in_ready    = in_ready_c;
  assign bus.err_sync    = err_sync_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.dbg_state   = state_q;

endmodule
